// File: rtl/hslp_pkg.sv
// -----------------------------------------------------------------------------
// hslp_pkg
// Shared types and helpers for the sequential HSLP approximate-multiply
// controller: FSM state encoding, the 2-bit partial-product step index, the
// per-step shift weights and the nibble selectors that map a step onto the
// operand halves.
// -----------------------------------------------------------------------------
package hslp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  // Step bit1 selects the A nibble, bit0 selects the B nibble.
  localparam step_t STEP_LL = 2'd0;
  localparam step_t STEP_LH = 2'd1;
  localparam step_t STEP_HL = 2'd2;
  localparam step_t STEP_HH = 2'd3;

  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_HH = 4'd8;

  function automatic logic [3:0] step_shift(input step_t s);
    logic [3:0] r;
    case (s)
      STEP_LL: r = SHIFT_LL;
      STEP_LH: r = SHIFT_LH;
      STEP_HL: r = SHIFT_HL;
      default: r = SHIFT_HH;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] nib_a(input logic [7:0] v, input step_t s);
    return s[1] ? v[7:4] : v[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] v, input step_t s);
    return s[0] ? v[7:4] : v[3:0];
  endfunction

endpackage

// File: rtl/hslp_step_sel.sv
// -----------------------------------------------------------------------------
// hslp_step_sel
// Combinational next-live-step finder.
//   a, b        : operand bytes the steps are evaluated against
//   cur         : current step index
//   from_start  : 1 = search all steps from LL, 0 = only steps above cur
//   next        : lowest qualifying live step (STEP_LL when none)
//   none        : no qualifying live step exists
// A step is live when skipping is disabled or both its nibbles are nonzero.
// -----------------------------------------------------------------------------
module hslp_step_sel
  import hslp_pkg::*;
#(
  parameter int ZERO_SKIP = 1
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  step_t      cur,
  input  logic       from_start,
  output step_t      next,
  output logic       none
);

  logic [3:0] live;
  logic [3:0] cand;

  for (genvar gi = 0; gi < 4; gi++) begin : g_step
    localparam step_t S = step_t'(gi);
    assign live[gi] = (ZERO_SKIP == 0) ||
                      ((nib_a(a, S) != 4'd0) && (nib_b(b, S) != 4'd0));
    assign cand[gi] = live[gi] && (from_start || (S > cur));
  end

  // Scan downwards so the lowest candidate wins.
  always_comb begin
    next = STEP_LL;
    none = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) begin
        next = step_t'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hslp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hslp_seq_ctrl
// Sequential 8x8 approximate multiply built on one shared external 4x4
// sub-multiplier. The four nibble partials (LL, LH, HL, HH) are issued one per
// cycle, each with its own approximation mode, and accumulated with their
// shift weights into a 16-bit wrapping sum.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, a/b sampled on acceptance
//   mul_en/a/b/mode      : sub-multiplier issue (all zero when not issuing)
//   mul_prod             : sub-multiplier result, same cycle as the issue
//   out_valid/out_ready  : result handshake, prod held until accepted
// Parameters: MODE_MAP bit per step (1 = ap2-class, 0 = ap1-class),
//             ZERO_SKIP (1 = skip partials with a zero nibble operand).
// -----------------------------------------------------------------------------
module hslp_seq_ctrl
  import hslp_pkg::*;
#(
  parameter logic [3:0] MODE_MAP  = 4'b0001,
  parameter int         ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        mul_en,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic        mul_mode,
  input  logic [7:0]  mul_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod
);

  state_t      state;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  step_t       step;
  logic [15:0] acc;

  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic        sel_start;
  step_t       sel_next;
  logic        sel_none;
  logic [15:0] acc_sum;

  // While idle the selector looks at the live port operands so the first
  // step is known at the accept edge; afterwards it follows the latched copy.
  assign sel_a     = (state == IDLE) ? a : a_reg;
  assign sel_b     = (state == IDLE) ? b : b_reg;
  assign sel_start = (state != CALC);

  hslp_step_sel #(
    .ZERO_SKIP (ZERO_SKIP)
  ) u_step_sel (
    .a          (sel_a),
    .b          (sel_b),
    .cur        (step),
    .from_start (sel_start),
    .next       (sel_next),
    .none       (sel_none)
  );

  // Wraps modulo 2^16: approximate partials may exceed the exact range.
  assign acc_sum = acc + ({8'h00, mul_prod} << step_shift(step));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      step      <= STEP_LL;
      acc       <= 16'h0000;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= 16'h0000;
      mul_en    <= 1'b0;
      mul_a     <= 4'h0;
      mul_b     <= 4'h0;
      mul_mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            acc      <= 16'h0000;
            in_ready <= 1'b0;
            if (sel_none) begin
              state     <= DONE;
              prod      <= 16'h0000;
              out_valid <= 1'b1;
            end else begin
              state    <= CALC;
              step     <= sel_next;
              mul_en   <= 1'b1;
              mul_a    <= nib_a(a, sel_next);
              mul_b    <= nib_b(b, sel_next);
              mul_mode <= MODE_MAP[sel_next];
            end
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (sel_none) begin
            state     <= DONE;
            prod      <= acc_sum;
            out_valid <= 1'b1;
            mul_en    <= 1'b0;
            mul_a     <= 4'h0;
            mul_b     <= 4'h0;
            mul_mode  <= 1'b0;
          end else begin
            step     <= sel_next;
            mul_a    <= nib_a(a_reg, sel_next);
            mul_b    <= nib_b(b_reg, sel_next);
            mul_mode <= MODE_MAP[sel_next];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          mul_en    <= 1'b0;
          mul_a     <= 4'h0;
          mul_b     <= 4'h0;
          mul_mode  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hslp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hslp_seq_ctrl
// Two controller instances: g[0] with ZERO_SKIP=0 / MODE_MAP=0001 and g[1]
// with ZERO_SKIP=1 / MODE_MAP=1010. Each has a driver pushing expectations
// from a step-sum reference model and a monitor popping and comparing issues,
// latency and products.
// -----------------------------------------------------------------------------
module tb_hslp_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  // Sub-multiplier stand-in: 0 = exact, 1 = mode-dependent distortion,
  // 2 = constant 0xFF stub.
  function automatic logic [7:0] sub_fn(input int kind, input logic m,
                                        input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = {4'd0, x} * {4'd0, y};
    if (kind == 2) return 8'hFF;
    if (kind == 1 && m) return p ^ 8'hA5;
    return p;
  endfunction

  // Product = sum over live steps of sub(nibbles) * 2^weight, mod 2^16.
  function automatic void model(input int zs, input logic [3:0] map, input int kind,
                                input logic [7:0] av, input logic [7:0] bv,
                                output logic [15:0] p, output int n,
                                output logic [35:0] iss);
    logic [3:0] an, bn;
    int w;
    p = 16'h0000; n = 0; iss = '0;
    for (int i = 0; i < 4; i++) begin
      an = (i >= 2) ? av[7:4] : av[3:0];
      bn = (i % 2 == 1) ? bv[7:4] : bv[3:0];
      if (zs == 0 || (an != 4'd0 && bn != 4'd0)) begin
        w = (i == 0) ? 0 : ((i == 3) ? 8 : 4);
        p = p + 16'((32'(sub_fn(kind, map[i], an, bn)) * (1 << w)) % 65536);
        iss[n*9 +: 9] = {map[i], an, bn};
        n++;
      end
    end
  endfunction

  task automatic chk(input int inst, input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL g%0d.%s: got 0x%0h expected 0x%0h", inst, name, act, expv);
    end
  endtask

  task automatic bad(input int inst, input string name);
    tests++;
    fails++;
    $display("FAIL g%0d.%s: got event expected none", inst, name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int         ZS  = gi;
    localparam logic [3:0] MAP = (gi == 0) ? 4'b0001 : 4'b1010;

    logic        rst_n, in_valid, in_ready, mul_en, mul_mode, out_valid, out_ready;
    logic [7:0]  a, b, mul_prod;
    logic [3:0]  mul_a, mul_b;
    logic [15:0] prod;
    int          kind = 0;
    bit          done = 1'b0;

    exp_t        exp_q[$];
    logic [8:0]  iss_q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        prev_ov;
    logic [8:0]  ie;
    exp_t        ee;

    hslp_seq_ctrl #(
      .MODE_MAP  (MAP),
      .ZERO_SKIP (ZS)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mul_en    (mul_en),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_mode  (mul_mode),
      .mul_prod  (mul_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod)
    );

    assign mul_prod = sub_fn(kind, mul_mode, mul_a, mul_b);

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        iss_q.delete();
        prev_ov <= 1'b0;
      end else begin
        if (in_valid && in_ready) acc_cyc <= cyc;
        if (mul_en) begin
          if (iss_q.size() == 0) bad(gi, "unexpected_issue");
          else begin
            ie = iss_q.pop_front();
            chk(gi, "mul_mode", int'(mul_mode), int'(ie[8]));
            chk(gi, "mul_a", int'(mul_a), int'(ie[7:4]));
            chk(gi, "mul_b", int'(mul_b), int'(ie[3:0]));
          end
        end else begin
          chk(gi, "idle_mul_operands", int'({mul_mode, mul_a, mul_b}), 0);
        end
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) bad(gi, "unexpected_out_valid");
          else chk(gi, "latency", cyc - acc_cyc, exp_q[0].lat);
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          ee = exp_q.pop_front();
          chk(gi, "prod", int'(prod), int'(ee.prod));
        end
        prev_ov <= out_valid;
      end
    end

    task automatic chk_reset();
      chk(gi, "rst_in_ready", int'(in_ready), 1);
      chk(gi, "rst_out_valid", int'(out_valid), 0);
      chk(gi, "rst_prod", int'(prod), 0);
      chk(gi, "rst_mul_en", int'(mul_en), 0);
      chk(gi, "rst_mul_a", int'(mul_a), 0);
      chk(gi, "rst_mul_b", int'(mul_b), 0);
      chk(gi, "rst_mul_mode", int'(mul_mode), 0);
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output logic [15:0] expv);
      logic [15:0] p;
      int n, t;
      logic [35:0] iss;
      exp_t e;
      model(ZS, MAP, kind, av, bv, p, n, iss);
      a = av; b = bv; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 40) begin tick(); t++; end
      if (!in_ready) bad(gi, "accept_timeout");
      else begin
        e.prod = p; e.lat = n + 1;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) iss_q.push_back(iss[i*9 +: 9]);
      end
      expv = p;
      tick();
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic wait_done();
      int t;
      t = 0;
      while (!out_valid && t < 20) begin tick(); t++; end
      if (!out_valid) bad(gi, "done_timeout");
    endtask

    task automatic finish_op(input int delay);
      wait_done();
      repeat (delay) tick();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
      logic [15:0] ev;
      logic [7:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst_n = 1'b1;
      tick();

      kind = 0; do_op(8'hB7, 8'h5E, ev); finish_op(0);
      do_op(8'h30, 8'h07, ev); finish_op(1);
      do_op(8'h00, 8'hC4, ev); finish_op(0);
      kind = 2; do_op(8'h11, 8'h11, ev); finish_op(0); kind = 0;

      // Backpressure with new operands waiting.
      do_op(8'hA9, 8'h6C, ev);
      wait_done();
      in_valid = 1'b1; a = 8'h4D; b = 8'h92;
      repeat (3) begin
        chk(gi, "bp_out_valid", int'(out_valid), 1);
        chk(gi, "bp_in_ready", int'(in_ready), 0);
        chk(gi, "bp_prod", int'(prod), int'(ev));
        tick();
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk(gi, "bp_release_in_ready", int'(in_ready), 1);
      chk(gi, "bp_release_out_valid", int'(out_valid), 0);
      do_op(8'h4D, 8'h92, ev); finish_op(0);

      // Asynchronous reset during the second CALC step.
      do_op(8'h5A, 8'h3C, ev);
      tick();
      #2 rst_n = 1'b0;
      #1 chk_reset();
      tick(); rst_n = 1'b1; tick();
      do_op(8'h12, 8'h34, ev); finish_op(0);

      for (int k = 0; k < 120; k++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        case ($urandom % 4)
          0: ra = ra & 8'hF0;
          1: rb = rb & 8'h0F;
          default: ;
        endcase
        kind = int'($urandom % 2);
        repeat ($urandom % 2) tick();
        do_op(ra, rb, ev);
        finish_op(int'($urandom % 3));
      end
      repeat (4) tick();
      chk(gi, "drained", exp_q.size() + iss_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int c;
    c = 0;
    while (!(g[0].done && g[1].done) && c < 50000) begin
      @(posedge clk);
      c++;
    end
    if (!(g[0].done && g[1].done)) begin
      tests++;
      fails++;
      $display("FAIL global_timeout: got running expected done");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
